// File: rtl/delay_credit_fifo_pkg.sv
// Shared definitions for the delay-pipeline credit FIFO: error-bit indices
// and a pointer-increment helper that wraps at any depth (not only powers of 2).
package delay_credit_pkg;

    localparam int ERR_OVF    = 0;
    localparam int ERR_CREDIT = 1;

    // Advance a circular pointer, wrapping from depth-1 back to 0.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        if (ptr + 1 >= depth)
            return 0;
        else
            return ptr + 1;
    endfunction

endpackage

// File: rtl/delay_credit_fifo_mem.sv
// Register-array storage for the credit FIFO: one synchronous write port and
// one combinational read port. Contents are not reset.
module credit_fifo_mem
    import delay_credit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Capture the incoming word at the write pointer.
    always_ff @(posedge clk) begin
        if (we)
            mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/delay_credit_fifo.sv
// Receiver for the no-backpressure delay pipeline: absorbs in-flight words in
// a small FWFT FIFO and hands out launch credits so the FIFO cannot overflow.
// Optional build macro: DELAY_CREDIT_FIFO_STATS_EN adds the max_occ
// high-water-mark output.
module delay_credit_fifo
    import delay_credit_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    output logic             can_issue,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] credits,
    output logic [CNT_W-1:0] occupancy,
`ifdef DELAY_CREDIT_FIFO_STATS_EN
    output logic [CNT_W-1:0] max_occ,
`endif
    output logic [1:0]       err_sticky
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] credits_q, credits_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]       err_q, err_d;
    logic             push, pop;

    // Handshake decode: a full FIFO still accepts a word when the head leaves the same cycle.
    always_comb begin
        pop  = (occ_q != '0) && out_ready;
        push = in_valid && ((occ_q != DEPTH_C) || pop);
    end

    // Next-state for pointers, occupancy, credits and sticky errors.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        credits_d = credits_q;
        err_d     = err_q;

        if (push)
            wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        if (pop)
            rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));

        if (push && !pop)
            occ_d = occ_q + CNT_W'(1);
        else if (pop && !push)
            occ_d = occ_q - CNT_W'(1);

        // A credit leaves with each launch and returns when its word leaves the FIFO.
        case ({issue, pop})
            2'b10: begin
                if (credits_q != '0)
                    credits_d = credits_q - CNT_W'(1);
            end
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase

        if (issue && (credits_q == '0))
            err_d[ERR_CREDIT] = 1'b1;
        if (in_valid && !push)
            err_d[ERR_OVF] = 1'b1;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= DEPTH_C;
            occ_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= '0;
        end else begin
            credits_q <= credits_d;
            occ_q     <= occ_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
        end
    end

`ifdef DELAY_CREDIT_FIFO_STATS_EN
    logic [CNT_W-1:0] max_occ_q, max_occ_d;

    // High-water mark follows the occupancy being written this edge.
    always_comb begin
        max_occ_d = max_occ_q;
        if (occ_d > max_occ_q)
            max_occ_d = occ_d;
    end

    // High-water-mark register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            max_occ_q <= '0;
        else
            max_occ_q <= max_occ_d;
    end

    assign max_occ = max_occ_q;
`endif

    credit_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

    assign out_valid  = (occ_q != '0);
    assign can_issue  = (credits_q != '0);
    assign credits    = credits_q;
    assign occupancy  = occ_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_delay_credit_fifo.sv
// Directed bench for delay_credit_fifo: a DEPTH=16 instance for the fill,
// drain, overflow and credit scenarios, and a DEPTH=5 instance for pointer wrap.
module tb_delay_credit_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // DEPTH = 16 instance
    logic       issue = 1'b0;
    logic       can_issue;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [4:0] credits;
    logic [4:0] occupancy;
    logic [1:0] err_sticky;

    // DEPTH = 5 instance
    logic       d5_issue = 1'b0;
    logic       d5_can_issue;
    logic       d5_in_valid = 1'b0;
    logic [7:0] d5_in_data = 8'h00;
    logic       d5_out_valid;
    logic [7:0] d5_out_data;
    logic       d5_out_ready = 1'b0;
    logic [2:0] d5_credits;
    logic [2:0] d5_occ;
    logic [1:0] d5_err;

`ifdef DELAY_CREDIT_FIFO_STATS_EN
    logic [4:0] max_occ16;
    logic [2:0] d5_max_occ;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    delay_credit_fifo #(.WIDTH(8), .DEPTH(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .can_issue  (can_issue),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .credits    (credits),
        .occupancy  (occupancy),
`ifdef DELAY_CREDIT_FIFO_STATS_EN
        .max_occ    (max_occ16),
`endif
        .err_sticky (err_sticky)
    );

    delay_credit_fifo #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (d5_issue),
        .can_issue  (d5_can_issue),
        .in_valid   (d5_in_valid),
        .in_data    (d5_in_data),
        .out_valid  (d5_out_valid),
        .out_data   (d5_out_data),
        .out_ready  (d5_out_ready),
        .credits    (d5_credits),
        .occupancy  (d5_occ),
`ifdef DELAY_CREDIT_FIFO_STATS_EN
        .max_occ    (d5_max_occ),
`endif
        .err_sticky (d5_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        issue = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        d5_issue = 1'b0; d5_in_valid = 1'b0; d5_out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++;
        if (credits !== 5'd16 || can_issue !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_credits: got credits=%0d can_issue=%b, want 16/1", credits, can_issue);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 5'd0 || err_sticky !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: got out_valid=%b occ=%0d err=%b, want 0/0/00", out_valid, occupancy, err_sticky);
        end
        n_cmp++;
        if (d5_credits !== 3'd5 || d5_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_d5: got credits=%0d out_valid=%b, want 5/0", d5_credits, d5_out_valid);
        end
`ifdef DELAY_CREDIT_FIFO_STATS_EN
        n_cmp++;
        if (max_occ16 !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_max_occ: got %0d want 0", max_occ16);
        end
`endif
    endtask

    // 16 issues on consecutive cycles, each word arriving 4 cycles after its issue.
    task automatic fill16;
        for (int c = 0; c < 20; c++) begin
            if (c == 4) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_no_bypass: got out_valid=%b want 0", out_valid);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 8'h00) begin
                    n_fail++;
                    $display("FAIL fill_first_head: got valid=%b data=%h want 1/00", out_valid, out_data);
                end
            end
            if (c == 15) begin
                n_cmp++;
                if (credits !== 5'd1 || can_issue !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fill_last_credit: got credits=%0d can_issue=%b want 1/1", credits, can_issue);
                end
            end
            if (c == 16) begin
                n_cmp++;
                if (credits !== 5'd0 || can_issue !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_no_credit: got credits=%0d can_issue=%b want 0/0", credits, can_issue);
                end
            end
            issue    = (c < 16);
            in_valid = (c >= 4);
            in_data  = 8'(c - 4);
            tick;
        end
        issue = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (occupancy !== 5'd16 || credits !== 5'd0) begin
            n_fail++;
            $display("FAIL fill_full: got occ=%0d credits=%0d want 16/0", occupancy, credits);
        end
    endtask

    task automatic drain_seq(input logic [7:0] first, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'(first + 8'(i))) begin
                n_fail++;
                $display("FAIL drain_word%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, 8'(first + 8'(i)));
            end
            tick;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fill_drain;
        fill16;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL hold_head: got valid=%b data=%h want 1/00", out_valid, out_data);
        end
        drain_seq(8'h00, 16);
        n_cmp++;
        if (credits !== 5'd16 || occupancy !== 5'd0 || out_valid !== 1'b0 || err_sticky !== 2'b00) begin
            n_fail++;
            $display("FAIL drain_end: got credits=%0d occ=%0d valid=%b err=%b want 16/0/0/00",
                     credits, occupancy, out_valid, err_sticky);
        end
    endtask

    task automatic test_full_push_pop;
        fill16;
        in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        tick;
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (occupancy !== 5'd16 || out_data !== 8'h01 || err_sticky !== 2'b00) begin
            n_fail++;
            $display("FAIL full_push_pop: got occ=%0d head=%h err=%b want 16/01/00", occupancy, out_data, err_sticky);
        end
    endtask

    task automatic test_overflow;
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        n_cmp++;
        if (err_sticky !== 2'b01 || occupancy !== 5'd16) begin
            n_fail++;
            $display("FAIL overflow: got err=%b occ=%0d want 01/16", err_sticky, occupancy);
        end
        drain_seq(8'h01, 15);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
            n_fail++;
            $display("FAIL last_word: got valid=%b data=%h want 1/aa", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 5'd0 || err_sticky !== 2'b01) begin
            n_fail++;
            $display("FAIL dropped_word: got valid=%b occ=%0d err=%b want 0/0/01", out_valid, occupancy, err_sticky);
        end
    endtask

    task automatic test_credit_underflow;
        do_reset;
        issue = 1'b1;
        repeat (16) tick;
        n_cmp++;
        if (credits !== 5'd0 || err_sticky !== 2'b00) begin
            n_fail++;
            $display("FAIL credits_exhausted: got credits=%0d err=%b want 0/00", credits, err_sticky);
        end
        tick;
        n_cmp++;
        if (credits !== 5'd0 || err_sticky !== 2'b10 || can_issue !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_underflow: got credits=%0d err=%b can_issue=%b want 0/10/0",
                     credits, err_sticky, can_issue);
        end
        // Asynchronous reset in the middle of traffic clears state without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (credits !== 5'd16 || err_sticky !== 2'b00 || can_issue !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got credits=%0d err=%b can_issue=%b want 16/00/1",
                     credits, err_sticky, can_issue);
        end
        issue = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick;
    endtask

    // DEPTH=5 traffic through a 4-stage delay model, with stalls on both sides.
    task automatic test_wrap_d5;
        bit         h_v [4];
        logic [7:0] h_d [4];
        int         issued, popped, exp_next, peak, inflight;
        bit         iss;
        logic [7:0] nd;
        issued = 0; popped = 0; exp_next = 0; peak = 0;
        for (int j = 0; j < 4; j++) begin
            h_v[j] = 1'b0;
            h_d[j] = 8'h00;
        end
        for (int k = 0; k < 125; k++) begin
            inflight = 0;
            for (int j = 0; j < 4; j++) inflight += int'(h_v[j]);
            n_cmp++;
            if (int'(d5_credits) + int'(d5_occ) + inflight != 5) begin
                n_fail++;
                $display("FAIL d5_invariant cyc%0d: got credits=%0d occ=%0d inflight=%0d want sum 5",
                         k, d5_credits, d5_occ, inflight);
            end
            if (int'(d5_occ) > peak) peak = int'(d5_occ);
            d5_out_ready = (k % 3 != 0);
            if (d5_out_valid && d5_out_ready) begin
                n_cmp++;
                if (d5_out_data !== 8'(exp_next)) begin
                    n_fail++;
                    $display("FAIL d5_order word%0d: got %h want %h", exp_next, d5_out_data, 8'(exp_next));
                end
                exp_next++;
                popped++;
            end
            iss         = (k < 100) && d5_can_issue && (k % 7 != 3);
            nd          = 8'(issued);
            d5_issue    = iss;
            d5_in_valid = h_v[3];
            d5_in_data  = h_d[3];
            if (iss) issued++;
            tick;
            for (int j = 3; j > 0; j--) begin
                h_v[j] = h_v[j-1];
                h_d[j] = h_d[j-1];
            end
            h_v[0] = iss;
            h_d[0] = nd;
        end
        d5_issue = 1'b0; d5_in_valid = 1'b0; d5_out_ready = 1'b0;
        n_cmp++;
        if (popped != issued || issued < 20 || d5_occ !== 3'd0 || d5_credits !== 3'd5 || d5_err !== 2'b00) begin
            n_fail++;
            $display("FAIL d5_totals: got issued=%0d popped=%0d occ=%0d credits=%0d err=%b want equal/0/5/00",
                     issued, popped, d5_occ, d5_credits, d5_err);
        end
`ifdef DELAY_CREDIT_FIFO_STATS_EN
        n_cmp++;
        if (int'(d5_max_occ) != peak) begin
            n_fail++;
            $display("FAIL d5_max_occ: got %0d want %0d", d5_max_occ, peak);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_fill_drain;
        test_full_push_pop;
        test_overflow;
        test_credit_underflow;
        test_wrap_d5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/delay_credit_fifo.md
Name: delay_credit_fifo

Overview:
- Receiver stage downstream of the fixed-latency register pipeline in the merge datapath.
- The pipeline has no backpressure path, so this block absorbs in-flight words in a small FIFO.
- It tells the upstream issuer when it may launch a word through a credit counter, so the FIFO never overflows.
- It presents a valid/ready stream to the next merge stage.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, FIFO entries; must be >= 2 and >= the pipeline stage count for full throughput; need not be a power of 2.
- CNT_W, $clog2(DEPTH+1), derived width of the occupancy and credit counters; not overridden.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- issue  input  1  upstream launched one word into the delay pipeline this cycle.
- can_issue  output  1  credit available; upstream may assert issue only when this is 1.
- in_valid  input  1  word arriving from the delay pipeline output.
- in_data  input  WIDTH  arriving word.
- out_valid  output  1  FIFO head valid.
- out_data  output  WIDTH  FIFO head word.
- out_ready  input  1  downstream accepts the head.
- credits  output  CNT_W  current credit count.
- occupancy  output  CNT_W  current FIFO entry count.
- err_sticky  output  2  bit0 = overflow (push while full), bit1 = credit underflow (issue with zero credits).

Behaviour:
- Reset (async assert, sync release):
  - credits = DEPTH, occupancy = 0, rd_ptr = wr_ptr = 0, err_sticky = 0.
  - out_valid = 0, can_issue = 1.
  - Storage contents are don't-care.
- Credit counter:
  - issue && !pop: decrement.
  - pop && !issue: increment.
  - issue && pop: unchanged.
  - can_issue = (credits != 0), combinational from the register.
- Credit underflow: issue while credits == 0 leaves credits at 0 (no wrap) and sets err_sticky[1].
- Push: push = in_valid && (occupancy != DEPTH || pop).
  - Writes in_data at wr_ptr.
  - wr_ptr wraps from DEPTH-1 to 0.
- Overflow: in_valid while full without a same-cycle pop drops the word and sets err_sticky[0].
- Pop and output:
  - pop = out_valid && out_ready.
  - rd_ptr wraps from DEPTH-1 to 0.
  - First-word-fall-through: out_valid = (occupancy != 0); out_data = storage[rd_ptr], combinational from registers.
  - out_data is held stable while out_valid && !out_ready.
- Occupancy: push only increments; pop only decrements; both leaves it unchanged.
- Full + simultaneous push and pop: both accepted, occupancy stays DEPTH.
- Empty + push: out_valid rises the cycle after in_valid; no bypass path. Latency from arrival to head is 1 cycle.
- Throughput: 1 word/cycle sustained when out_ready stays high.
- Invariant, legal use: credits + occupancy + words in flight == DEPTH at every edge.
- err_sticky bits clear only on reset.
- Reset mid-operation clears all state immediately. In-flight words arriving after release are pushed normally (credits may later exceed the true count; that is a system-level reset-ordering requirement on upstream, not a block error).

Optional Feature:
- Macro: DELAY_CREDIT_FIFO_STATS_EN.
- Defined:
  - Adds output max_occ [CNT_W]: the high-water mark of occupancy since reset.
  - Updated on the edge where the new occupancy exceeds the stored value.
  - Reset to 0.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Shared package delay_credit_pkg holds:
  - the error-bit index constants ERR_OVF = 0 and ERR_CREDIT = 1;
  - a helper function for pointer increment with wrap at an arbitrary DEPTH.
- One sub-module, credit_fifo_mem, is natural:
  - register-array storage with a write port (we, waddr, wdata) and a combinational read (raddr, rdata);
  - no reset on storage.
- Counters, pointers and error logic stay in the top module.

Test Plan:
- Reset then idle -> credits = 16, can_issue = 1, out_valid = 0, err_sticky = 0.
- 16 issues on consecutive cycles, words 0x00..0x0F arriving 4 cycles later, out_ready = 0:
  - credits reach 0 after the 16th issue, can_issue = 0, occupancy = 16;
  - then out_ready = 1 drains 0x00..0x0F in order, one per cycle, and credits return to 16.
- Full FIFO, same-cycle in_valid (0xAA) and pop -> occupancy stays 16, head advances, 0xAA is read last, err_sticky = 0.
- in_valid with 0x55 while full and out_ready = 0 -> word dropped, err_sticky = 2'b01, occupancy stays 16.
- issue with credits = 0 -> credits stay 0, err_sticky[1] = 1.
- Continuous issue/arrive/pop for 100 cycles with DEPTH = 5 (forcing pointer wrap) -> output sequence matches input, invariant holds. With DELAY_CREDIT_FIFO_STATS_EN defined, max_occ equals the peak occupancy.
